// File: rtl/sha256_msg_padder.sv
// Purpose: byte-stream front end for the SHA-256 compression core. Collects
// message bytes into a 64-byte block, applies padding (0x80, zero fill,
// 64-bit big-endian bit length) and hands each 512-bit block to the core
// with a single-cycle start pulse, waiting for the core between blocks.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready byte stream handshake (in_data, in_last)
//   block_out         block to core block_in, held from start until the next block build
//   first_run         core first_run, high for the first block of each message
//   start             core start, one-cycle pulse per block
//   core_ready        core ready output
//   msg_done          one-cycle pulse when the final block of a message is hashed
//   busy              message in progress
module sha256_msg_padder #(
  parameter int unsigned LEN_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] block_out,
  output logic         first_run,
  output logic         start,
  input  logic         core_ready,
  output logic         msg_done,
  output logic         busy
);

  localparam int unsigned BLK_W    = 512;
  localparam int unsigned PTR_W    = 6;
  localparam int unsigned LEN_BITS = 64;

  typedef enum logic [2:0] {
    S_ACCEPT,
    S_PAD80,
    S_PADZ,
    S_PADLEN,
    S_SEND,
    S_WAITC,
    S_GAP
  } state_t;

  state_t             state, state_d;
  state_t             ret, ret_d;        // state to resume after a block is hashed
  logic [PTR_W-1:0]   ptr, ptr_d;
  logic [LEN_W-1:0]   cnt, cnt_d;
  logic [BLK_W-1:0]   blk_d;
  logic               final_blk, final_d;
  logic               start_d, first_d, done_d, busy_d;
  logic [8:0]         wr_msb;
  logic               accept;

  // Byte k lives at block_out[511-8k -: 8]
  assign wr_msb   = 9'(BLK_W - 1) - {ptr, 3'b000};

  // Ready only in ACCEPT and never while reset is applied
  assign in_ready = (state == S_ACCEPT) && !rst;
  assign accept   = in_valid && in_ready;

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    ret_d   = ret;
    ptr_d   = ptr;
    cnt_d   = cnt;
    blk_d   = block_out;
    final_d = final_blk;
    first_d = first_run;
    done_d  = 1'b0;

    unique case (state)
      S_ACCEPT: begin
        if (accept) begin
          blk_d[wr_msb -: 8] = in_data;
          ptr_d = ptr + PTR_W'(1);
          cnt_d = cnt + LEN_W'(1);
          if (ptr == PTR_W'(63)) begin
            // Full block: ship it first, padding (if last) continues in a fresh block
            state_d = S_SEND;
            ret_d   = in_last ? S_PAD80 : S_ACCEPT;
          end else if (in_last) begin
            state_d = S_PAD80;
          end
        end
      end

      S_PAD80: begin
        blk_d[wr_msb -: 8] = 8'h80;
        ptr_d = ptr + PTR_W'(1);
        if (ptr == PTR_W'(63)) begin
          state_d = S_SEND;
          ret_d   = S_PADZ;
        end else begin
          state_d = S_PADZ;
        end
      end

      S_PADZ: begin
        // ptr only reaches 56 in the block that will carry the length field;
        // past 56 we zero-fill to the end, send, and wrap around
        if (ptr == PTR_W'(56)) begin
          state_d = S_PADLEN;
        end else begin
          blk_d[wr_msb -: 8] = 8'h00;
          ptr_d = ptr + PTR_W'(1);
          if (ptr == PTR_W'(63)) begin
            state_d = S_SEND;
            ret_d   = S_PADZ;
          end
        end
      end

      S_PADLEN: begin
        blk_d[LEN_BITS-1:0] = LEN_BITS'({cnt, 3'b000});
        ptr_d   = '0;
        final_d = 1'b1;
        state_d = S_SEND;
        ret_d   = S_ACCEPT;
      end

      S_SEND: begin
        state_d = S_WAITC;
      end

      S_WAITC: begin
        if (core_ready) begin
          first_d = final_blk;
          done_d  = final_blk;
          if (final_blk) begin
            cnt_d = '0;
          end
          final_d = 1'b0;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        // Lets the core leave its done state before the next start
        state_d = ret;
      end

      default: begin
        state_d = S_ACCEPT;
      end
    endcase

    start_d = (state_d == S_SEND);
    busy_d  = !((state_d == S_ACCEPT) && (ptr_d == '0) && (cnt_d == '0));
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ACCEPT;
      ret       <= S_ACCEPT;
      ptr       <= '0;
      cnt       <= '0;
      block_out <= '0;
      final_blk <= 1'b0;
      start     <= 1'b0;
      first_run <= 1'b1;
      msg_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      ret       <= ret_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      block_out <= blk_d;
      final_blk <= final_d;
      start     <= start_d;
      first_run <= first_d;
      msg_done  <= done_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed testbench for sha256_msg_padder with a small latency model of the core.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_ready;
  logic [511:0] block_out;
  logic         first_run;
  logic         start;
  logic         core_ready;
  logic         msg_done;
  logic         busy;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int inready_viol = 0;
  int core_lat = 3;
  int core_cnt = 0;
  logic [511:0] blk_q[$];
  logic         fr_q[$];

  always #5 clk = ~clk;

  sha256_msg_padder #(.LEN_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .block_out  (block_out),
    .first_run  (first_run),
    .start      (start),
    .core_ready (core_ready),
    .msg_done   (msg_done),
    .busy       (busy)
  );

  // Core model: ready drops after start, returns after core_lat cycles
  always @(posedge clk) begin
    if (rst) begin
      core_ready <= 1'b1;
      core_cnt   <= 0;
    end else if (start) begin
      core_ready <= 1'b0;
      core_cnt   <= core_lat;
    end else if (!core_ready) begin
      if (core_cnt <= 1) core_ready <= 1'b1;
      else core_cnt <= core_cnt - 1;
    end
  end

  // Capture every block handed to the core
  always @(negedge clk) begin
    if (start) begin
      start_cnt++;
      blk_q.push_back(block_out);
      fr_q.push_back(first_run);
      if (in_ready) inready_viol++;
    end
    if (msg_done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed no finish expected finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] get_blk(input int i);
    if (blk_q.size() > i) return blk_q[i];
    return 'x;
  endfunction

  function automatic logic get_fr(input int i);
    if (fr_q.size() > i) return fr_q[i];
    return 1'bx;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic l);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && guard < 500) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $error("FAIL send_timeout observed in_ready=0 expected 1");
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  // Bytes are 8'(i*mul + add)
  task automatic send_msg(input int n, input int mul, input int add, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_byte(8'(i * mul + add), (i == n - 1));
      if (gaps) repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic wait_done(input int n);
    int guard = 0;
    while (done_cnt < n && guard < 3000) begin
      tick();
      guard++;
    end
    if (done_cnt < n) begin
      tests++;
      fails++;
      $error("FAIL done_timeout observed %0d expected %0d", done_cnt, n);
    end
    repeat (3) tick();
  endtask

  task automatic wait_starts(input int n);
    int guard = 0;
    while (start_cnt < n && guard < 3000) begin
      tick();
      guard++;
    end
    if (start_cnt < n) begin
      tests++;
      fails++;
      $error("FAIL start_timeout observed %0d expected %0d", start_cnt, n);
    end
  endtask

  initial begin
    logic [511:0] e0, e1, g0, g1, held;
    int sb, db;
    logic rdy_seen, blk_changed;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (3) tick();
    chk("in_ready_in_rst", 512'(in_ready), 512'(0));
    rst = 1'b0;
    tick();
    chk("rst_block_out", block_out, 512'h0);
    chk("rst_start", 512'(start), 512'(0));
    chk("rst_first_run", 512'(first_run), 512'(1));
    chk("rst_msg_done", 512'(msg_done), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_in_ready", 512'(in_ready), 512'(1));

    // "abc"
    blk_q.delete(); fr_q.delete(); sb = start_cnt; db = done_cnt;
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    chk("busy_mid_msg", 512'(busy), 512'(1));
    send_byte(8'h63, 1'b1);
    wait_done(db + 1);
    chk("abc_block", get_blk(0), {32'h61626380, 416'h0, 64'h18});
    chk("abc_first_run", 512'(get_fr(0)), 512'(1));
    chk("abc_starts", 512'(start_cnt - sb), 512'(1));
    chk("abc_done", 512'(done_cnt - db), 512'(1));
    chk("abc_busy_after", 512'(busy), 512'(0));

    // 55 zero bytes: single block
    blk_q.delete(); fr_q.delete(); sb = start_cnt; db = done_cnt;
    send_msg(55, 0, 0, 1'b0);
    wait_done(db + 1);
    chk("z55_block", get_blk(0), {440'h0, 8'h80, 64'h1B8});
    chk("z55_starts", 512'(start_cnt - sb), 512'(1));

    // 56 bytes (i): two blocks
    blk_q.delete(); fr_q.delete(); sb = start_cnt; db = done_cnt;
    send_msg(56, 1, 0, 1'b0);
    wait_done(db + 1);
    e0 = '0;
    for (int i = 0; i < 56; i++) e0[511 - 8 * i -: 8] = 8'(i);
    e0[511 - 8 * 56 -: 8] = 8'h80;
    chk("m56_blk0", get_blk(0), e0);
    chk("m56_blk1", get_blk(1), {448'h0, 64'h1C0});
    chk("m56_fr0", 512'(get_fr(0)), 512'(1));
    chk("m56_fr1", 512'(get_fr(1)), 512'(0));
    chk("m56_starts", 512'(start_cnt - sb), 512'(2));
    chk("m56_done", 512'(done_cnt - db), 512'(1));
    chk("m56_first_run_after", 512'(first_run), 512'(1));

    // 64 bytes (i+1), back to back then with random gaps
    e1 = '0;
    for (int i = 0; i < 64; i++) e1[511 - 8 * i -: 8] = 8'(i + 1);
    blk_q.delete(); fr_q.delete(); db = done_cnt;
    send_msg(64, 1, 1, 1'b0);
    wait_done(db + 1);
    g0 = get_blk(0); g1 = get_blk(1);
    chk("m64_blk0", g0, e1);
    chk("m64_blk1", g1, {8'h80, 440'h0, 64'h200});
    blk_q.delete(); fr_q.delete(); db = done_cnt;
    send_msg(64, 1, 1, 1'b1);
    wait_done(db + 1);
    chk("m64g_blk0", get_blk(0), g0);
    chk("m64g_blk1", get_blk(1), {8'h80, 440'h0, 64'h200});
    chk("inready_in_send", 512'(inready_viol), 512'(0));

    // Core held busy for 100 cycles
    core_lat = 100;
    blk_q.delete(); fr_q.delete(); sb = start_cnt; db = done_cnt;
    send_msg(56, 1, 0, 1'b0);
    wait_starts(sb + 1);
    tick();
    held = block_out;
    rdy_seen = 1'b0; blk_changed = 1'b0;
    repeat (90) begin
      tick();
      if (in_ready) rdy_seen = 1'b1;
      if (block_out !== held) blk_changed = 1'b1;
    end
    chk("hold_starts", 512'(start_cnt - sb), 512'(1));
    chk("hold_in_ready", 512'(rdy_seen), 512'(0));
    chk("hold_block", 512'(blk_changed), 512'(0));
    wait_done(db + 1);
    chk("hold_blk0", get_blk(0), e0);
    chk("hold_blk1", get_blk(1), {448'h0, 64'h1C0});
    core_lat = 3;

    // Reset during zero fill of a 2-block message
    blk_q.delete(); fr_q.delete(); sb = start_cnt; db = done_cnt;
    send_msg(56, 1, 0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_in_ready_in_rst", 512'(in_ready), 512'(0));
    chk("mrst_start", 512'(start), 512'(0));
    chk("mrst_first_run", 512'(first_run), 512'(1));
    chk("mrst_block", block_out, 512'h0);
    rst = 1'b0;
    #1;
    chk("mrst_in_ready", 512'(in_ready), 512'(1));
    chk("mrst_busy", 512'(busy), 512'(0));
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    wait_done(db + 1);
    chk("mrst_abc_block", get_blk(0), {32'h61626380, 416'h0, 64'h18});
    chk("mrst_abc_fr", 512'(get_fr(0)), 512'(1));
    chk("mrst_starts", 512'(start_cnt - sb), 512'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
